reg_wb_scoreboard: RTL and testbench
====================================

Name: reg_wb_scoreboard

Overview:
- Controller in front of the register file (`NUM` entries, entry 0 hard-wired zero).
- Tracks one pending-write busy bit per register and stalls instruction issue on RAW/WAW hazards.
- Arbitrates `NWB` writeback requesters (ALU, FPU, load unit) round-robin, one write per cycle.
- Drives the register file's flat `inreg` data bus and per-register `enable` vector directly.

Parameters:
- WIDTH, 32, register data width (matches common.h `WIDTH`)
- NUM, 64, register count (r0-r31 integer, r32-r63 float)
- AW, 6, register address width, equal to clog2(NUM)
- NWB, 3, number of writeback requesters

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- issue_valid  in  1  decode stage presents an instruction
- issue_ready  out  1  instruction accepted this cycle
- issue_rs1  in  AW  source register 1
- issue_rs2  in  AW  source register 2
- issue_rd  in  AW  destination register
- issue_rd_we  in  1  instruction writes issue_rd
- wb_valid  in  NWB  writeback request per port
- wb_addr  in  NWB*AW  destination per port, flat, port k at [k*AW +: AW]
- wb_data  in  NWB*WIDTH  data per port, flat, port k at [k*WIDTH +: WIDTH]
- wb_ready  out  NWB  one-hot grant; the request completes on the same edge
- rf_inreg  out  WIDTH*NUM  to register file inreg
- rf_enable  out  NUM  to register file enable
- busy  out  NUM  busy vector, registered
- wb_err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous on rstn low:
  - busy = 0, rr_ptr = 0, wb_err = 0.
  - Outputs are combinational from state and inputs, so with no wb_valid: rf_enable = 0, wb_ready = 0.
- Arbitration:
  - Search wb_valid starting at index rr_ptr, wrapping modulo NWB; the first valid port g is granted.
  - wb_ready[g] = 1, all other bits 0. No valid ports means no grant.
  - On a grant, rr_ptr <= (g+1) mod NWB. With no grant, rr_ptr holds.
- Register drive:
  - Every WIDTH slice of rf_inreg equals wb_data of port g; it is don't-care, driven 0, when there is no grant.
  - rf_enable[a] = 1 only for a = wb_addr[g] with a != 0. rf_enable[0] is always 0.
  - The register file captures the value on the same clk edge as the grant; zero added latency.
- Writeback to r0: grant still issued so the requester drains; no enable, no busy change.
- Issue hazard check:
  - hazard = busy[rs1] | busy[rs2] | (issue_rd_we & busy[rd]).
  - busy[0] is never set, so r0 sources never stall.
- issue_ready = !hazard. It is independent of issue_valid, so there is no combinational loop.
- Issue handshake: issue_valid & issue_ready with issue_rd_we & rd != 0 sets busy[rd] at the next edge.
- Busy clear: granted writeback to address a != 0 clears busy[a] at the next edge.
- Same register, same cycle, issue set and writeback clear: the set wins and busy stays 1. Only reachable with SB_BYPASS_EN, since WAW otherwise stalls.
- Error: a granted writeback to a != 0 with busy[a] = 0 sets wb_err = 1 until reset. The write is still performed.
- Throughput: one writeback and one issue per cycle, concurrently.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined:
  - The hazard check uses busy_eff = busy & ~clr, where clr is the one-hot clear from this cycle's grant.
  - An instruction whose source or destination is written back this cycle issues in the same cycle.
  - Its operand read happens one cycle later and sees the new value.
- Undefined:
  - The hazard check uses registered busy only, giving one extra stall cycle after writeback.
  - The set-and-clear collision described above cannot occur.

Decomposition:
- Shared package/header (common.h alongside WIDTH/NUM):
  - AW constant
  - NWB default
  - r0 index constant ZERO_REG = 0
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], clk, rstn.
  - Outputs: one-hot gnt[N] and gnt_idx.
  - Owns rr_ptr.
- Scoreboard logic stays in the top module.

Test Plan:
- Reset then idle: busy = 0, rf_enable = 0, issue_ready = 1 with any rs values, wb_err = 0.
- RAW stall:
  - Issue rd = 5 (rd_we = 1), then issue rs1 = 5 -> issue_ready = 0.
  - wb port1 addr 5 data 0xDEADBEEF -> rf_enable[5] = 1 and slice 5 = 0xDEADBEEF.
  - Next cycle busy[5] = 0 and issue_ready = 1; with SB_BYPASS_EN, issue_ready = 1 in the writeback cycle itself.
- Round-robin:
  - All three wb_valid held high with addresses 7, 8, 9 (pre-marked busy) -> grants in order 0, 1, 2.
  - After port 0 drops, grants continue 1, 2, 1, 2.
  - rr_ptr wraps 2 -> 0.
- r0 handling:
  - Issue rd = 0 with rd_we = 1 -> busy unchanged, next issue never stalls.
  - wb addr 0 -> wb_ready = 1, rf_enable = 0, wb_err stays 0.
- WAW stall and error:
  - With busy[33] = 1, issue rd = 33 with rd_we -> ready = 0.
  - wb to addr 40 with busy[40] = 0 -> write happens and wb_err = 1 sticky.
- Async reset mid-operation: rstn low while busy = 0x0000_0000_0000_00A0 and rr_ptr = 2 -> immediately busy = 0, rr_ptr = 0, wb_err = 0.

Source files
------------

// File: rtl/reg_wb_scoreboard_pkg.sv
// Shared constants and helpers for the register writeback scoreboard.
// Optional feature macro: SB_BYPASS_EN (same-cycle hazard release on writeback).
package reg_wb_scoreboard_pkg;

  localparam int WIDTH = 32;
  localparam int NUM   = 64;
  localparam int AW    = $clog2(NUM);
  localparam int NWB   = 3;

  localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

  // One-hot register select with r0 suppressed: r0 never gets an enable
  // and never gets a busy bit.
  function automatic logic [NUM-1:0] reg_onehot(input logic [AW-1:0] addr,
                                                input logic          en);
    logic [NUM-1:0] v;
    v = {NUM{1'b0}};
    if (en && (addr != ZERO_REG)) begin
      v[addr] = 1'b1;
    end else begin
      v = {NUM{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_wb_scoreboard_if.sv
// Issue, writeback and register-file signals of the scoreboard.
// master = decode/writeback side driver, slave = the scoreboard itself.
interface reg_wb_scoreboard_if;
  import reg_wb_scoreboard_pkg::*;

  logic                   issue_valid;
  logic                   issue_ready;
  logic [AW-1:0]          issue_rs1;
  logic [AW-1:0]          issue_rs2;
  logic [AW-1:0]          issue_rd;
  logic                   issue_rd_we;
  logic [NWB-1:0]         wb_valid;
  logic [NWB*AW-1:0]      wb_addr;
  logic [NWB*WIDTH-1:0]   wb_data;
  logic [NWB-1:0]         wb_ready;
  logic [WIDTH*NUM-1:0]   rf_inreg;
  logic [NUM-1:0]         rf_enable;
  logic [NUM-1:0]         busy;
  logic                   wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    output wb_valid, wb_addr, wb_data,
    input  issue_ready, wb_ready, rf_inreg, rf_enable, busy, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    input  wb_valid, wb_addr, wb_data,
    output issue_ready, wb_ready, rf_inreg, rf_enable, busy, wb_err
  );

endinterface

// File: rtl/reg_wb_scoreboard_rr_arbiter.sv
// Round-robin arbiter: search starts at rr_q and wraps modulo N; the pointer
// moves to one past the winner on a grant and holds otherwise.
module reg_wb_scoreboard_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [IW-1:0] idx_s;

  // First requester at or after rr_q (circularly) wins.
  always_comb begin
    gnt       = {N{1'b0}};
    gnt_idx   = {IW{1'b0}};
    gnt_valid = 1'b0;
    idx_s     = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_s = IW'((int'(rr_q) + i) % N);
      if (!gnt_valid && req[idx_s]) begin
        gnt_valid  = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
      end else begin
        // an earlier port in search order already won, or no request here
      end
    end
  end

  // Pointer advance: one past the granted port.
  always_comb begin
    rr_d = rr_q;
    if (gnt_valid) begin
      rr_d = IW'((int'(gnt_idx) + 1) % N);
    end else begin
      rr_d = rr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= {IW{1'b0}};
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/reg_wb_scoreboard.sv
// Register writeback scoreboard: per-register busy bits, RAW/WAW issue stall,
// round-robin writeback arbitration and direct register-file drive.
// Optional feature macro: SB_BYPASS_EN -- a writeback granted this cycle
// releases the hazard on its register in the same cycle.
module reg_wb_scoreboard
  import reg_wb_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  reg_wb_scoreboard_if.slave   bus
);

  localparam int IW = (NWB > 1) ? $clog2(NWB) : 1;

  logic [NWB-1:0]   gnt_s;
  logic [IW-1:0]    gnt_idx_s;
  logic             gnt_valid_s;
  logic [AW-1:0]    wb_addr_g_s;
  logic [WIDTH-1:0] wb_data_g_s;
  logic [NUM-1:0]   clr_s;
  logic [NUM-1:0]   set_s;
  logic [NUM-1:0]   busy_eff_s;
  logic             hazard_s;
  logic             issue_fire_s;

  logic [NUM-1:0]   busy_q;
  logic [NUM-1:0]   busy_d;
  logic             wb_err_q;
  logic             wb_err_d;

  reg_wb_scoreboard_rr_arbiter #(.N(NWB), .IW(IW)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (bus.wb_valid),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Winning port's address/data; data forced to zero when nobody is granted.
  always_comb begin
    wb_addr_g_s = bus.wb_addr[int'(gnt_idx_s)*AW +: AW];
    wb_data_g_s = {WIDTH{1'b0}};
    if (gnt_valid_s) begin
      wb_data_g_s = bus.wb_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
    end else begin
      wb_data_g_s = {WIDTH{1'b0}};
    end
  end

  // Writeback to r0 is granted (so the requester drains) but writes nothing.
  assign clr_s = reg_onehot(wb_addr_g_s, gnt_valid_s);

`ifdef SB_BYPASS_EN
  assign busy_eff_s = busy_q & ~clr_s;
`else
  assign busy_eff_s = busy_q;
`endif

  // Hazard and issue accept; ready does not look at issue_valid.
  always_comb begin
    hazard_s = busy_eff_s[bus.issue_rs1] | busy_eff_s[bus.issue_rs2] |
               (bus.issue_rd_we & busy_eff_s[bus.issue_rd]);
    issue_fire_s = bus.issue_valid & ~hazard_s;
  end

  assign set_s = reg_onehot(bus.issue_rd, issue_fire_s & bus.issue_rd_we);

  // Next busy vector: set wins over a same-cycle clear; error is sticky.
  always_comb begin
    busy_d   = (busy_q & ~clr_s) | set_s;
    wb_err_d = wb_err_q | (|(clr_s & ~busy_q));
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q   <= {NUM{1'b0}};
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.issue_ready = ~hazard_s;
  assign bus.wb_ready    = gnt_s;
  assign bus.rf_enable   = clr_s;
  assign bus.rf_inreg    = {NUM{wb_data_g_s}};
  assign bus.busy        = busy_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed self-checking bench for reg_wb_scoreboard.
module tb_reg_wb_scoreboard;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

`ifdef SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_wb_scoreboard_if sb ();

  reg_wb_scoreboard dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic [5:0] rd, input logic we);
    sb.issue_valid = v;
    sb.issue_rs1   = rs1;
    sb.issue_rs2   = rs2;
    sb.issue_rd    = rd;
    sb.issue_rd_we = we;
  endtask

  task automatic wb(input logic [2:0] v, input logic [5:0] a0, input logic [5:0] a1,
                    input logic [5:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [31:0] d2);
    sb.wb_valid = v;
    sb.wb_addr  = {a2, a1, a0};
    sb.wb_data  = {d2, d1, d0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    issue(1'b0, 6'd5, 6'd63, 6'd12, 1'b1);
    wb(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    #3;
    // reset / idle
    chk("rst_busy", sb.busy, 64'd0);
    chk("rst_enable", sb.rf_enable, 64'd0);
    chk("rst_wb_ready", {61'd0, sb.wb_ready}, 64'd0);
    chk("rst_wb_err", {63'd0, sb.wb_err}, 64'd0);
    chk("rst_issue_ready", {63'd0, sb.issue_ready}, 64'd1);
    tick();
    rstn = 1'b1;
    tick();
    chk("idle_ready", {63'd0, sb.issue_ready}, 64'd1);

    // RAW stall
    issue(1'b1, 6'd0, 6'd0, 6'd5, 1'b1);
    #1;
    chk("raw_first_ready", {63'd0, sb.issue_ready}, 64'd1);
    tick();
    chk("raw_busy5", sb.busy, 64'h20);
    issue(1'b1, 6'd5, 6'd0, 6'd6, 1'b1);
    #1;
    chk("raw_stall", {63'd0, sb.issue_ready}, 64'd0);
    tick();
    chk("raw_no_set", sb.busy, 64'h20);
    issue(1'b0, 6'd5, 6'd0, 6'd6, 1'b1);
    wb(3'b010, 6'd0, 6'd5, 6'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    #1;
    chk("raw_wb_ready", {61'd0, sb.wb_ready}, 64'd2);
    chk("raw_enable", sb.rf_enable, 64'h20);
    chk("raw_slice5", {32'd0, sb.rf_inreg[5*32 +: 32]}, 64'hDEADBEEF);
    chk("raw_slice0", {32'd0, sb.rf_inreg[31:0]}, 64'hDEADBEEF);
    chk("raw_bypass_ready", {63'd0, sb.issue_ready}, {63'd0, BYP});
    tick();
    wb(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("raw_busy_clr", sb.busy, 64'd0);
    chk("raw_ready_after", {63'd0, sb.issue_ready}, 64'd1);
    chk("raw_enable_idle", sb.rf_enable, 64'd0);
    chk("raw_rr2", {62'd0, dut.u_arb.rr_q}, 64'd2);

    // mark r7..r9 busy
    issue(1'b1, 6'd0, 6'd0, 6'd7, 1'b1);
    tick();
    issue(1'b1, 6'd0, 6'd0, 6'd8, 1'b1);
    tick();
    issue(1'b1, 6'd0, 6'd0, 6'd9, 1'b1);
    tick();
    issue(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    chk("rr_premark", sb.busy, 64'h380);

    // writeback to r0 on port 2: granted, no write, pointer wraps 2 -> 0
    wb(3'b100, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'h0BAD0BAD);
    #1;
    chk("r0_wb_ready", {61'd0, sb.wb_ready}, 64'd4);
    chk("r0_enable", sb.rf_enable, 64'd0);
    tick();
    chk("r0_wb_err", {63'd0, sb.wb_err}, 64'd0);
    chk("r0_busy", sb.busy, 64'h380);
    chk("rr_wrap", {62'd0, dut.u_arb.rr_q}, 64'd0);

    // round robin with all three ports
    wb(3'b111, 6'd7, 6'd8, 6'd9, 32'h70, 32'h80, 32'h90);
    #1;
    chk("rr_g0", {61'd0, sb.wb_ready}, 64'd1);
    chk("rr_en7", sb.rf_enable, 64'h80);
    chk("rr_d0", {32'd0, sb.rf_inreg[7*32 +: 32]}, 64'h70);
    tick();
    chk("rr_g1", {61'd0, sb.wb_ready}, 64'd2);
    chk("rr_en8", sb.rf_enable, 64'h100);
    tick();
    chk("rr_g2", {61'd0, sb.wb_ready}, 64'd4);
    chk("rr_en9", sb.rf_enable, 64'h200);
    tick();
    chk("rr_busy_clr", sb.busy, 64'd0);
    chk("rr_no_err", {63'd0, sb.wb_err}, 64'd0);
    wb(3'b110, 6'd0, 6'd0, 6'd0, 32'd0, 32'h1, 32'h2);
    #1;
    chk("rr_h1", {61'd0, sb.wb_ready}, 64'd2);
    tick();
    chk("rr_h2", {61'd0, sb.wb_ready}, 64'd4);
    tick();
    chk("rr_h3", {61'd0, sb.wb_ready}, 64'd2);
    tick();
    chk("rr_h4", {61'd0, sb.wb_ready}, 64'd4);
    tick();
    wb(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("rr_idle_ready", {61'd0, sb.wb_ready}, 64'd0);
    chk("rr_h_err", {63'd0, sb.wb_err}, 64'd0);

    // issue to r0 never marks busy
    issue(1'b1, 6'd0, 6'd0, 6'd0, 1'b1);
    tick();
    chk("r0_issue_busy", sb.busy, 64'd0);
    chk("r0_issue_ready", {63'd0, sb.issue_ready}, 64'd1);

    // WAW stall
    issue(1'b1, 6'd0, 6'd0, 6'd33, 1'b1);
    tick();
    chk("waw_busy33", sb.busy, 64'h2_0000_0000);
    #1;
    chk("waw_stall", {63'd0, sb.issue_ready}, 64'd0);
    tick();
    chk("waw_hold", sb.busy, 64'h2_0000_0000);
    issue(1'b0, 6'd0, 6'd0, 6'd33, 1'b0);
    #1;
    chk("waw_no_we_ready", {63'd0, sb.issue_ready}, 64'd1);

    // unexpected writeback to r40: performed, error sticky
    wb(3'b001, 6'd40, 6'd0, 6'd0, 32'h12345678, 32'd0, 32'd0);
    #1;
    chk("err_wb_ready", {61'd0, sb.wb_ready}, 64'd1);
    chk("err_enable", sb.rf_enable, 64'h100_0000_0000);
    chk("err_slice40", {32'd0, sb.rf_inreg[40*32 +: 32]}, 64'h12345678);
    chk("err_pre", {63'd0, sb.wb_err}, 64'd0);
    tick();
    wb(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    chk("err_set", {63'd0, sb.wb_err}, 64'd1);
    chk("err_busy", sb.busy, 64'h2_0000_0000);
    tick();
    chk("err_sticky", {63'd0, sb.wb_err}, 64'd1);

    // build busy=0xA0, rr=2, then asynchronous reset
    wb(3'b010, 6'd0, 6'd33, 6'd0, 32'd0, 32'h33, 32'd0);
    tick();
    wb(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 6'd0, 6'd0, 6'd5, 1'b1);
    tick();
    issue(1'b1, 6'd0, 6'd0, 6'd7, 1'b1);
    tick();
    issue(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    chk("pre_rst_busy", sb.busy, 64'hA0);
    chk("pre_rst_rr", {62'd0, dut.u_arb.rr_q}, 64'd2);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_busy", sb.busy, 64'd0);
    chk("arst_rr", {62'd0, dut.u_arb.rr_q}, 64'd0);
    chk("arst_err", {63'd0, sb.wb_err}, 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", {63'd0, sb.issue_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
